// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// display modes, the blank pattern and the active-low hex glyph table.
package seg7_pkg;

  localparam logic [1:0] MODE_HEX     = 2'b00;
  localparam logic [1:0] MODE_RAW     = 2'b01;
  localparam logic [1:0] MODE_HEX_LZB = 2'b10;
  localparam logic [1:0] MODE_BLANK   = 2'b11;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry k occupies bits [8k+7:8k]; glyph for 0 sits in the low byte.
  localparam logic [127:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[8*nibble +: 8];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-source side of the scan controller: data/control inputs and the
// segment/select/frame outputs, with the source as master and controller as slave.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [8*NUM_DIGITS-1:0] i_data;
  logic [1:0]              disp_mode;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blink;
  logic [2:0]              i_bright;
  logic                    i_freeze;
  logic [7:0]              o_seg;
  logic [NUM_DIGITS-1:0]   o_sel;
  logic                    o_frame;

  modport master (
    output i_data, disp_mode, i_dp, i_blink, i_bright, i_freeze,
    input  o_seg, o_sel, o_frame
  );

  modport slave (
    input  i_data, disp_mode, i_dp, i_blink, i_bright, i_freeze,
    output o_seg, o_sel, o_frame
  );

endinterface

// File: rtl/seg7_hex_enc.sv
// Combinational nibble to active-low seven-segment glyph (dp bit left off).
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = hex_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous data capture,
// leading-zero blanking, per-digit dp/blink, PWM brightness and freeze.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 15,
  parameter int unsigned BLINK_DIV  = 25
) (
  input logic             clk,
  input logic             rstn,
  seg7_scan_ctrl_if.slave bus
);
  import seg7_pkg::*;

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] Digit0Sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [SCAN_DIV-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BLINK_DIV-1:0]    blink_q, blink_d;
  logic [8*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_q, frame_d;

  logic       tick;
  logic       frame_edge;
  logic [3:0] nibble;
  logic [7:0] hex_glyph;
  logic [7:0] raw_byte;
  logic [2:0] phase;
  logic       lz_blank;
  logic       lit;

  seg7_hex_enc u_hex_enc (
    .nibble_i (nibble),
    .seg_o    (hex_glyph)
  );

  // Scan/blink counters and the frame-synchronous shadow capture.
  always_comb begin
    tick       = &cnt_q;
    frame_edge = tick && (idx_q == LastIdx);
    cnt_d      = cnt_q + 1'b1;
    blink_d    = blink_q + 1'b1;
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    shadow_d = (frame_edge && !bus.i_freeze) ? bus.i_data : shadow_q;
    frame_d  = frame_edge;
  end

  // A digit blanks only if it and every more-significant nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
    if (idx_q != '0) begin
      lz_blank = 1'b1;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
        if (j >= 32'(idx_q) && shadow_q[4*j +: 4] != 4'h0) begin
          lz_blank = 1'b0;
        end
      end
    end
  end

  always_comb begin
    nibble   = shadow_q[4*idx_q +: 4];
    raw_byte = shadow_q[8*idx_q +: 8];
    phase    = cnt_q[SCAN_DIV-1 -: 3];
    lit      = (phase <= bus.i_bright) &&
               !(bus.i_blink[idx_q] && blink_q[BLINK_DIV-1]) &&
               (bus.disp_mode != MODE_BLANK);
    seg_d    = SEG_OFF;
    sel_d    = '1;
    if (lit) begin
      sel_d = ~(Digit0Sel << idx_q);
      case (bus.disp_mode)
        MODE_RAW:     seg_d = raw_byte;
        MODE_HEX_LZB: seg_d = {!bus.i_dp[idx_q], lz_blank ? 7'h7F : hex_glyph[6:0]};
        default:      seg_d = {!bus.i_dp[idx_q], hex_glyph[6:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      sel_q    <= '1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.o_seg   = seg_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_frame = frame_q;

endmodule
